uart_receive: RTL and testbench
===============================

Name: uart_receive

Overview:
- Serial-to-parallel UART receiver. It is the stage directly downstream of the team's Send transmitter and consumes its serial line.
- Recovers 8N1 frames (LSB first, idle-high) from an asynchronous input.
- Presents each received byte as a one-cycle valid pulse with data, ready for the echo/display logic.
- Default timing targets a 100 MHz clk at 115200 baud.

Parameters:
- BIT_CYCLES, 868, clk cycles per serial bit. Must be at least 4 and even.
- HALF_CYCLES, BIT_CYCLES/2, cycles from the start-bit falling edge to the start-bit centre.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- din  input  1  serial line from the transmitter or pin. Asynchronous to clk; idles at 1.
- din_vld  output  1  one-cycle pulse: din_data holds a valid received byte.
- din_data  output  8  received byte. Held stable until the next din_vld.
- frame_err  output  1  one-cycle pulse: stop bit was sampled as 0.

Behaviour:
- Reset (rst=0, takes effect asynchronously):
  - state=IDLE, all counters 0, shift register 0.
  - din_vld=0, din_data=8'h00, frame_err=0.
  - Synchronizer flops and the previous-sample flop reset to 1.
- Input conditioning:
  - din passes through a 2-flop synchronizer to give din_s.
  - A third flop holds the previous din_s.
  - A falling edge is din_s_prev=1 and din_s=0.
- States: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, go to START and clear the bit counter cnt.
    - A line held low does not retrigger.
  - START: cnt increments each cycle.
    - At cnt=HALF_CYCLES-1, sample din_s.
    - If din_s=0, clear cnt, clear bit index idx, and go to DATA.
    - If din_s=1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: cnt counts 0..BIT_CYCLES-1.
    - At the terminal count, shift din_s into the MSB of the shift register (LSB-first reception) and increment idx.
    - After the 8th sample (idx was 7), go to STOP.
  - STOP: cnt counts 0..BIT_CYCLES-1. At the terminal count, sample din_s and return to IDLE.
    - din_s=1: next cycle din_vld=1 and din_data=shift register.
    - din_s=0: next cycle frame_err=1. din_data is unchanged and din_vld stays 0.
- Latency: t0 is the clk cycle in which the falling edge is detected on din_s.
  - Data bit i is sampled at t0+HALF_CYCLES+(i+1)*BIT_CYCLES.
  - Stop bit is sampled at t0+HALF_CYCLES+9*BIT_CYCLES.
  - din_vld is asserted one cycle after the stop-bit sample.
  - Pin-to-din_s adds 2 cycles.
- din_vld and frame_err are never asserted together, and each lasts exactly 1 cycle.
- Back-to-back frames: the receiver is in IDLE from mid-stop-bit onward, so a start edge arriving at or after the nominal stop-bit end is caught. Zero inter-frame gap is supported.
- Line activity during DATA or STOP does not restart the frame. Edges are ignored outside IDLE.
- Reset mid-frame aborts the frame immediately. No din_vld is produced for the partial frame.
- Baud tolerance: the sample point is centred, so ±2% clock mismatch over 10 bits must decode correctly.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1.
  - A state PARITY sits between DATA and STOP and samples one bit at its centre.
  - An extra output parity_err (1 bit, reset 0) pulses for one cycle with din_vld when the XOR of the 8 data bits and the parity bit is 1.
  - din_vld still asserts on a good stop bit, and din_data is still updated.
  - The stop sample time shifts by BIT_CYCLES.
- Undefined: no PARITY state and no parity_err port. Behaviour is exactly 8N1 as above.

Test Plan:
- Reset: hold rst=0 with din toggling, then release. Required: din_vld=0, frame_err=0, din_data=8'h00 until the first complete frame.
- Single byte, BIT_CYCLES=16: drive the frame for "0" (8'h30; bits 0,0,0,0,1,1,0,0 LSB first, then stop=1). Required: one din_vld pulse with din_data=8'h30, exactly HALF_CYCLES+9*16+3 cycles after the pin falling edge.
- Glitch: pulse din low for 3 cycles, then high. Required: return to IDLE, no din_vld, no frame_err.
- Frame error: send 8'hA5 with stop bit=0 and hold din low for 40 bit times. Required: one frame_err pulse, no din_vld, din_data keeps its previous value, and no retrigger until din rises and falls again.
- Back-to-back with no gap: send 8'h55 then 8'hFF, 8'h00. Required: three din_vld pulses with 8'h55, 8'hFF, 8'h00, each exactly 10*BIT_CYCLES apart.
- Loopback (BIT_CYCLES=868): connect the Send stage's dout to din and send "0". Required: din_vld with din_data=8'h30. Also assert rst=0 mid-DATA; required: no din_vld for that frame, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_receive.sv
// uart_receive: UART receiver recovering 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), LSB first, idle-high.
// Latency: din_vld/frame_err pulse one cycle after the stop-bit centre sample; the pin-to-din_s path adds 2 cycles.
// Backpressure: none; each byte is a single-cycle pulse and din_data holds until the next good frame.
module uart_receive #(
  parameter int BIT_CYCLES  = 868,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       din_vld,
  output logic [7:0] din_data,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // Input conditioning: two-flop synchronizer plus the previous-sample flop.
  logic sync_q, din_s_q, din_s_prev_q;
  logic din_s;

  assign din_s = din_s_q;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic [7:0]    data_q, data_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  // Synchronize the asynchronous line; flops reset to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 1'b1;
      din_s_q      <= 1'b1;
      din_s_prev_q <= 1'b1;
    end else begin
      sync_q       <= din;
      din_s_q      <= sync_q;
      din_s_prev_q <= din_s_q;
    end
  end

  // Frame sequencer: start-edge qualification, centred bit sampling and output pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a line stuck low cannot retrigger.
        if (din_s_prev_q && !din_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (!din_s) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = 3'd0;
          end else begin
            // Line back high at the start-bit centre: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {din_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = din_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Leaving at mid-stop-bit keeps zero-gap back-to-back frames catchable.
          cnt_d   = '0;
          state_d = IDLE;
          if (din_s) begin
            vld_d  = 1'b1;
            data_d = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d = (^shift_q) ^ par_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign din_vld   = vld_q;
  assign din_data  = data_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed + randomized frames against a frame-level reference model.
// Instance A runs at 16 cycles/bit, instance B at the default 868 cycles/bit.
// Expected events come from the sent byte/stop bit and the start time; observed pulses are queued by monitors.
module tb_uart_receive;

  localparam int BC    = 16;
  localparam int HC    = BC / 2;
  localparam int BCL   = 868;
  localparam int HCL   = BCL / 2;
  localparam int LAT_A = HC + 9 * BC + 3;
  localparam int LAT_B = HCL + 9 * BCL + 3;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         t;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, din_a, vld_a, ferr_a;
  logic [7:0] data_a;
  logic       rst_b, din_b, vld_b, ferr_b;
  logic [7:0] data_b;

  uart_receive #(.BIT_CYCLES(BC)) u_dut_a (
    .clk(clk), .rst(rst_a), .din(din_a),
    .din_vld(vld_a), .din_data(data_a), .frame_err(ferr_a)
  );

  uart_receive #(.BIT_CYCLES(BCL)) u_dut_b (
    .clk(clk), .rst(rst_b), .din(din_b),
    .din_vld(vld_b), .din_data(data_b), .frame_err(ferr_b)
  );

  int vectors = 0;
  int miscompares = 0;

  ev_t obs_a[$], exp_a[$], obs_b[$], exp_b[$];
  int  bad_a = 0, bad_b = 0;
  logic vld_a_p = 1'b0, ferr_a_p = 1'b0, vld_b_p = 1'b0, ferr_b_p = 1'b0;
  logic [7:0] last_a = 8'h00;

  // Monitors: record every output pulse and flag overlapping or stretched pulses.
  always @(negedge clk) begin
    if (vld_a === 1'b1 || ferr_a === 1'b1) obs_a.push_back('{ferr_a, data_a, cyc});
    if (vld_a === 1'b1 && ferr_a === 1'b1) bad_a++;
    if ((vld_a === 1'b1 && vld_a_p === 1'b1) || (ferr_a === 1'b1 && ferr_a_p === 1'b1)) bad_a++;
    vld_a_p = vld_a;
    ferr_a_p = ferr_a;
    if (vld_b === 1'b1 || ferr_b === 1'b1) obs_b.push_back('{ferr_b, data_b, cyc});
    if (vld_b === 1'b1 && ferr_b === 1'b1) bad_b++;
    if ((vld_b === 1'b1 && vld_b_p === 1'b1) || (ferr_b === 1'b1 && ferr_b_p === 1'b1)) bad_b++;
    vld_b_p = vld_b;
    ferr_b_p = ferr_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start bit, 8 data bits LSB first and the stop bit; must be entered right after a negedge.
  task automatic tx_frame(input bit sel, input logic [7:0] b, input logic stop,
                          input int per, output int c0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (sel) din_b = bits[i];
      else din_a = bits[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic send_a(input logic [7:0] b, input logic stop);
    int c0;
    tx_frame(1'b0, b, stop, BC, c0);
    if (stop) begin
      exp_a.push_back('{1'b0, b, c0 + LAT_A});
      last_a = b;
    end else begin
      exp_a.push_back('{1'b1, last_a, c0 + LAT_A});
    end
  endtask

  task automatic send_b(input logic [7:0] b, input int per);
    int c0;
    tx_frame(1'b1, b, 1'b1, per, c0);
    exp_b.push_back('{1'b0, b, c0 + LAT_B});
  endtask

  task automatic drain(input bit sel, input string tag);
    ev_t o, e;
    int no, ne;
    no = sel ? obs_b.size() : obs_a.size();
    ne = sel ? exp_b.size() : exp_a.size();
    check({tag, " count"}, no, ne);
    for (int k = 0; k < ne && k < no; k++) begin
      if (sel) begin o = obs_b[k]; e = exp_b[k]; end
      else begin o = obs_a[k]; e = exp_a[k]; end
      check({tag, " kind"}, {31'd0, o.err}, {31'd0, e.err});
      check({tag, " data"}, {24'd0, o.data}, {24'd0, e.data});
      check({tag, " time"}, o.t, e.t);
    end
    if (sel) begin obs_b.delete(); exp_b.delete(); end
    else begin obs_a.delete(); exp_a.delete(); end
  endtask

  initial begin
    int c;
    int gap;
    logic [7:0] b;
    logic stop;
    logic prev_bad;

    // Reset with the line toggling.
    rst_a = 1'b0; rst_b = 1'b0; din_a = 1'b1; din_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      din_a = 1'($urandom);
      din_b = 1'($urandom);
    end
    check("rst vld", {31'd0, vld_a}, 0);
    check("rst ferr", {31'd0, ferr_a}, 0);
    check("rst data", {24'd0, data_a}, 0);
    din_a = 1'b1; din_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (40) @(negedge clk);
    check("post-rst vld", {31'd0, vld_a}, 0);
    check("post-rst data", {24'd0, data_a}, 0);
    check("post-rst data b", {24'd0, data_b}, 0);
    drain(1'b0, "idle");

    // Single byte "0" with exact latency from the pin edge.
    send_a(8'h30, 1'b1);
    repeat (2 * BC) @(negedge clk);
    drain(1'b0, "single");

    // Three-cycle glitch must not produce any output.
    din_a = 1'b0;
    repeat (3) @(negedge clk);
    din_a = 1'b1;
    repeat (20 * BC) @(negedge clk);
    drain(1'b0, "glitch");
    check("glitch data", {24'd0, data_a}, 32'h30);

    // Bad stop bit, line held low for 40 bit times: one frame_err, data kept, no retrigger.
    send_a(8'hA5, 1'b0);
    repeat (40 * BC) @(negedge clk);
    din_a = 1'b1;
    repeat (2 * BC) @(negedge clk);
    drain(1'b0, "frame_err");
    check("ferr data kept", {24'd0, data_a}, 32'h30);

    // Zero-gap back-to-back frames.
    send_a(8'h55, 1'b1);
    send_a(8'hFF, 1'b1);
    send_a(8'h00, 1'b1);
    repeat (2 * BC) @(negedge clk);
    check("b2b n", obs_a.size(), 3);
    if (obs_a.size() == 3) begin
      check("b2b gap1", obs_a[1].t - obs_a[0].t, 10 * BC);
      check("b2b gap2", obs_a[2].t - obs_a[1].t, 10 * BC);
    end
    drain(1'b0, "b2b");

    // Randomized frames, occasional bad stop bits, random idle gaps.
    prev_bad = 1'b0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap = prev_bad ? BC + $urandom_range(0, BC) : $urandom_range(0, 2 * BC);
      din_a = 1'b1;
      repeat (gap) @(negedge clk);
      send_a(b, stop);
      prev_bad = !stop;
    end
    din_a = 1'b1;
    repeat (2 * BC) @(negedge clk);
    drain(1'b0, "random");
    check("pulse shape a", bad_a, 0);

    // Full-rate frame at the default bit time.
    repeat (BCL) @(negedge clk);
    send_b(8'h30, BCL);
    repeat (BCL) @(negedge clk);
    drain(1'b1, "loop");

    // Reset in the middle of the data bits aborts the frame.
    fork
      tx_frame(1'b1, 8'hC3, 1'b1, BCL, c);
      begin
        repeat (HCL + 3 * BCL) @(negedge clk);
        rst_b = 1'b0;
      end
    join
    check("midrst vld", {31'd0, vld_b}, 0);
    check("midrst data", {24'd0, data_b}, 0);
    din_b = 1'b1;
    repeat (BCL) @(negedge clk);
    rst_b = 1'b1;
    repeat (BCL) @(negedge clk);
    drain(1'b1, "midrst");
    send_b(8'($urandom), BCL);
    repeat (BCL) @(negedge clk);
    drain(1'b1, "after rst");

    // Transmitter 2% slow and 2% fast.
    send_b(8'($urandom), 885);
    repeat (BCL) @(negedge clk);
    send_b(8'($urandom), 851);
    repeat (BCL) @(negedge clk);
    drain(1'b1, "tolerance");
    check("pulse shape b", bad_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
